// File: rtl/bird_pkg.sv
// Shared encodings and widths for the flyhigh bird motion stage.
package bird_pkg;

    localparam int COORD_W = 12;
    localparam int VEL_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

endpackage

// File: rtl/flap_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous button.
module flap_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_edge
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // One-cycle pulse per press, regardless of how long the button is held.
    assign o_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/bird_motion.sv
// Per-frame bird physics and IDLE/FLY/DEAD game FSM; outputs the bird box.
// Build option: define BIRD_BOB_EN to make the idle bird bob +/-4 px.
module bird_motion
    import bird_pkg::*;
#(
    parameter int IX          = 160,
    parameter int IY          = 240,
    parameter int H_SIZE      = 16,
    parameter int D_HEIGHT    = 480,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 8,
    parameter int VMAX        = 12,
    parameter int DEAD_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_flap,
    input  logic               i_collide,
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2,
    output logic [1:0]         o_state,
    output logic               o_dead
);

    localparam int CNT_W = $clog2(DEAD_FRAMES + 1);

    localparam logic [COORD_W-1:0]        Y_START = COORD_W'(IY);
    localparam logic [COORD_W-1:0]        Y_FLOOR = COORD_W'(D_HEIGHT - H_SIZE);
    localparam logic [COORD_W-1:0]        Y_CEIL  = COORD_W'(H_SIZE);
    localparam logic signed [COORD_W:0]   FLOOR_S = (COORD_W + 1)'(D_HEIGHT - H_SIZE);
    localparam logic signed [COORD_W:0]   CEIL_S  = (COORD_W + 1)'(H_SIZE);
    localparam logic signed [VEL_W-1:0]   FLAP_S  = VEL_W'(-FLAP_VEL);
    localparam logic signed [VEL_W-1:0]   GRAV_S  = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0]   VMAX_S  = VEL_W'(VMAX);
    localparam logic [CNT_W-1:0]          CNT_END = CNT_W'(DEAD_FRAMES);

    state_e                    state_q;
    logic [COORD_W-1:0]        y_q;
    logic signed [VEL_W-1:0]   vel_q;
    logic                      flap_pend_q;
    logic [CNT_W-1:0]          dead_cnt_q;

    logic                      tick;
    logic                      flap_edge;
    logic                      flap_now;
    logic signed [COORD_W:0]   y_next;
    logic signed [VEL_W-1:0]   vel_grav;

    flap_sync u_flap_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_flap),
        .o_edge  (flap_edge)
    );

    assign tick     = i_ani_stb & i_animate;
    // An edge arriving on the tick cycle itself still counts for that tick.
    assign flap_now = flap_pend_q | flap_edge;
    assign y_next   = $signed({1'b0, y_q}) + (COORD_W + 1)'(vel_q);
    assign vel_grav = (vel_q > (VMAX_S - GRAV_S)) ? VMAX_S : (vel_q + GRAV_S);

`ifdef BIRD_BOB_EN
    logic                      bob_up_q;
    logic [COORD_W-1:0]        bob_y;
    logic                      bob_turn;

    assign bob_y    = bob_up_q ? (y_q - COORD_W'(1)) : (y_q + COORD_W'(1));
    assign bob_turn = (bob_y == COORD_W'(IY - 4)) || (bob_y == COORD_W'(IY + 4));
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= Y_START;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            dead_cnt_q  <= '0;
`ifdef BIRD_BOB_EN
            bob_up_q    <= 1'b1;
`endif
        end else begin
            if (tick) begin
                flap_pend_q <= 1'b0;
            end else if (flap_edge) begin
                flap_pend_q <= 1'b1;
            end

            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (flap_now) begin
                            state_q <= ST_FLY;
                            vel_q   <= FLAP_S;
                        end
`ifdef BIRD_BOB_EN
                        else begin
                            y_q <= bob_y;
                            if (bob_turn) bob_up_q <= ~bob_up_q;
                        end
`endif
                    end
                    ST_FLY: begin
                        // Position always moves by the velocity held before this tick.
                        if (i_collide) begin
                            state_q <= ST_DEAD;
                        end else if (y_next >= FLOOR_S) begin
                            y_q     <= Y_FLOOR;
                            vel_q   <= '0;
                            state_q <= ST_DEAD;
                        end else if (y_next < CEIL_S) begin
                            y_q   <= Y_CEIL;
                            vel_q <= flap_now ? FLAP_S : '0;
                        end else begin
                            y_q   <= y_next[COORD_W-1:0];
                            vel_q <= flap_now ? FLAP_S : vel_grav;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt_q != CNT_END) begin
                            dead_cnt_q <= dead_cnt_q + CNT_W'(1);
                        end else if (flap_now) begin
                            state_q    <= ST_IDLE;
                            y_q        <= Y_START;
                            vel_q      <= '0;
                            dead_cnt_q <= '0;
`ifdef BIRD_BOB_EN
                            bob_up_q   <= 1'b1;
`endif
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_x1    = COORD_W'(IX - H_SIZE);
    assign o_x2    = COORD_W'(IX + H_SIZE);
    assign o_y1    = y_q - COORD_W'(H_SIZE);
    assign o_y2    = y_q + COORD_W'(H_SIZE);
    assign o_state = state_q;
    assign o_dead  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: reset, flap trajectory, floor death, held flap,
// collision and dead-time lockout, IDLE re-entry and asynchronous reset.
module tb_bird_motion;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ani_stb;
    logic        i_animate;
    logic        i_flap;
    logic        i_collide;
    logic [11:0] o_x1;
    logic [11:0] o_x2;
    logic [11:0] o_y1;
    logic [11:0] o_y2;
    logic [1:0]  o_state;
    logic        o_dead;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    bird_motion dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_ani_stb (i_ani_stb),
        .i_animate (i_animate),
        .i_flap    (i_flap),
        .i_collide (i_collide),
        .o_x1      (o_x1),
        .o_x2      (o_x2),
        .o_y1      (o_y1),
        .o_y2      (o_y2),
        .o_state   (o_state),
        .o_dead    (o_dead)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick lasting one clock; returns at a negedge after the active edge.
    task automatic tick();
        @(negedge i_clk);
        i_ani_stb = 1'b1;
        i_animate = 1'b1;
        @(negedge i_clk);
        i_ani_stb = 1'b0;
        i_animate = 1'b0;
    endtask

    task automatic flap_pulse();
        @(negedge i_clk);
        i_flap = 1'b1;
        repeat (4) @(negedge i_clk);
        i_flap = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic check_y(input string tag, input int y, input int st);
        chk({tag, "_y1"}, int'(o_y1), y - 16);
        chk({tag, "_y2"}, int'(o_y2), y + 16);
        chk({tag, "_state"}, int'(o_state), st);
    endtask

    task automatic fly_from_queue(input string tag);
        logic [11:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            check_y(tag, int'(e), 1);
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_ani_stb = 1'b0;
        i_animate = 1'b0;
        i_flap    = 1'b0;
        i_collide = 1'b0;
        #12;
        chk("rst_x1", int'(o_x1), 144);
        chk("rst_x2", int'(o_x2), 176);
        check_y("rst", 240, 0);
        chk("rst_dead", int'(o_dead), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_y("idle", 240, 0);
        end

        // Flap from IDLE, rise to apex, then fall until the floor.
        flap_pulse();
        exp_q = {12'd240, 12'd232, 12'd225, 12'd219, 12'd214, 12'd210, 12'd207,
                 12'd205, 12'd204, 12'd204, 12'd205,
                 12'd207, 12'd210, 12'd214, 12'd219, 12'd225, 12'd232, 12'd240,
                 12'd249, 12'd259, 12'd270, 12'd282, 12'd294, 12'd306, 12'd318,
                 12'd330, 12'd342, 12'd354, 12'd366, 12'd378, 12'd390, 12'd402,
                 12'd414, 12'd426, 12'd438, 12'd450, 12'd462};
        fly_from_queue("fly");
        tick();
        check_y("floor", 464, 2);
        chk("floor_y2", int'(o_y2), 480);
        chk("floor_dead", int'(o_dead), 1);

        // Dead-time lockout: flaps in the first 60 dead ticks do nothing.
        for (int i = 1; i <= 60; i++) begin
            if (i == 30 || i == 60) flap_pulse();
            tick();
            check_y("dead_lock", 464, 2);
        end
        flap_pulse();
        tick();
        check_y("reidle", 240, 0);
        chk("reidle_dead", int'(o_dead), 0);

        flap_pulse();
        exp_q = {12'd240, 12'd232, 12'd225, 12'd219};
        fly_from_queue("fly2");

        // Button held across several ticks gives a single impulse.
        @(negedge i_clk);
        i_flap = 1'b1;
        repeat (4) @(negedge i_clk);
        exp_q = {12'd214, 12'd206, 12'd199, 12'd193};
        fly_from_queue("held");
        i_flap = 1'b0;
        repeat (4) @(negedge i_clk);

        // Collision wins over a pending flap; position frozen.
        flap_pulse();
        i_collide = 1'b1;
        tick();
        i_collide = 1'b0;
        check_y("collide", 193, 2);
        chk("collide_dead", int'(o_dead), 1);
        for (int i = 1; i <= 60; i++) begin
            if (i == 20 || i == 60) flap_pulse();
            tick();
            check_y("dead_lock2", 193, 2);
        end
        flap_pulse();
        tick();
        check_y("reidle2", 240, 0);

        flap_pulse();
        exp_q = {12'd240, 12'd232};
        fly_from_queue("fly3");

        // Asynchronous reset between ticks, sampled before any clock edge.
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_y("async_rst", 240, 0);
        chk("async_rst_dead", int'(o_dead), 0);
        chk("async_rst_x1", int'(o_x1), 144);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
